// File: rtl/ram_sp_bw_ctrl.sv
// Request front-end for a single-port byte-write RAM: valid/ready requests in,
// RAM port out, read data through a 2-entry response FIFO, plus a bulk-clear sweep.
module ram_sp_bw_ctrl #(
   parameter int BYTE_WIDTH_P = 4,
   parameter int ADDR_WIDTH_P = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [ADDR_WIDTH_P-1:0]     req_address,
   input  logic [BYTE_WIDTH_P*8-1:0]   req_data,
   input  logic [BYTE_WIDTH_P-1:0]     req_mask,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [BYTE_WIDTH_P*8-1:0]   rsp_data,
   input  logic                        clr_start,
   output logic                        clr_busy,
   output logic                        ram_enable,
   output logic                        ram_write_enable,
   output logic [ADDR_WIDTH_P-1:0]     ram_address,
   output logic [BYTE_WIDTH_P*8-1:0]   ram_data_ingress,
   output logic [BYTE_WIDTH_P-1:0]     ram_write_mask,
   input  logic [BYTE_WIDTH_P*8-1:0]   ram_data_egress
);

   localparam int DATA_W = BYTE_WIDTH_P * 8;

   typedef enum logic {
      RUN,
      CLEAR
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH_P-1:0] clr_addr;
   logic [DATA_W-1:0]       fifo_mem [2];
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              fifo_count;
   logic                    rd_pending;
   logic [1:0]              credit;
   logic                    rsp_pop;
   logic                    read_ok;
   logic                    req_fire;
   logic                    issue_write;
   logic                    issue_read;

   // A read reserves a FIFO slot now; a pop in the same cycle frees one for it.
   assign rsp_pop     = rsp_valid && rsp_ready;
   assign credit      = fifo_count + {1'b0, rd_pending};
   assign read_ok     = (credit < 2'd2) || ((credit == 2'd2) && rsp_pop);
   assign req_ready   = (state == RUN) && !clr_start && (req_write || read_ok);
   assign req_fire    = req_valid && req_ready;
   assign issue_write = req_fire && req_write;
   assign issue_read  = req_fire && !req_write;

   assign rsp_valid = (fifo_count != 2'd0);
   assign rsp_data  = fifo_mem[rd_ptr];

   always_comb begin
      ram_enable       = 1'b0;
      ram_write_enable = 1'b0;
      ram_address      = '0;
      ram_data_ingress = '0;
      ram_write_mask   = '0;
      if (state == CLEAR) begin
         ram_enable       = 1'b1;
         ram_write_enable = 1'b1;
         ram_address      = clr_addr;
         ram_write_mask   = '1;
      end else if (issue_write) begin
         ram_enable       = 1'b1;
         ram_write_enable = 1'b1;
         ram_address      = req_address;
         ram_data_ingress = req_data;
         ram_write_mask   = req_mask;
      end else if (issue_read) begin
         ram_enable       = 1'b1;
         ram_address      = req_address;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         clr_busy <= 1'b0;
         clr_addr <= '0;
      end else begin
         case (state)
            RUN: begin
               if (clr_start) begin
                  state    <= CLEAR;
                  clr_busy <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_addr == '1) begin
                  state    <= RUN;
                  clr_busy <= 1'b0;
                  clr_addr <= '0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: begin
               state    <= RUN;
               clr_busy <= 1'b0;
               clr_addr <= '0;
            end
         endcase
      end
   end

   // RAM read data arrives the cycle after issue and is captured unconditionally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pending  <= 1'b0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_count  <= 2'd0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
      end else begin
         rd_pending <= issue_read;
         if (rd_pending) begin
            fifo_mem[wr_ptr] <= ram_data_egress;
            wr_ptr           <= ~wr_ptr;
         end
         if (rsp_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({rd_pending, rsp_pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_sp_bw_ctrl.sv
// Randomized and directed bench for ram_sp_bw_ctrl with a behavioural RAM,
// a word-level reference memory and an in-order response scoreboard.
module tb_ram_sp_bw_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_address;
   logic [31:0] req_data;
   logic [3:0]  req_mask;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        clr_start;
   logic        clr_busy;
   logic        ram_enable;
   logic        ram_write_enable;
   logic [7:0]  ram_address;
   logic [31:0] ram_data_ingress;
   logic [3:0]  ram_write_mask;
   logic [31:0] ram_data_egress;

   logic [31:0] ram_mem [256];
   logic [31:0] ref_mem [256];
   logic [31:0] exp_q [$];

   int n_checks = 0;
   int n_fail = 0;
   int cycle = 0;
   int hs_cycle = 0;
   int rsp_count = 0;
   logic rand_ready = 1'b0;

   ram_sp_bw_ctrl #(.BYTE_WIDTH_P(4), .ADDR_WIDTH_P(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_write(req_write),
      .req_address(req_address),
      .req_data(req_data),
      .req_mask(req_mask),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_data(rsp_data),
      .clr_start(clr_start),
      .clr_busy(clr_busy),
      .ram_enable(ram_enable),
      .ram_write_enable(ram_write_enable),
      .ram_address(ram_address),
      .ram_data_ingress(ram_data_ingress),
      .ram_write_mask(ram_write_mask),
      .ram_data_egress(ram_data_egress)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = $urandom;
         ref_mem[i] = ram_mem[i];
      end
   end

   // Behavioural single-port RAM with 1-cycle read latency.
   always @(posedge clk) begin
      if (ram_enable) begin
         if (ram_write_enable) begin
            for (int b = 0; b < 4; b++)
               if (ram_write_mask[b]) ram_mem[ram_address][b*8 +: 8] <= ram_data_ingress[b*8 +: 8];
         end else begin
            ram_data_egress <= ram_mem[ram_address];
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) #1 rsp_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: accepted requests update a word memory; reads queue the expected word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (req_valid && req_ready) begin
            if (req_write) begin
               for (int b = 0; b < 4; b++)
                  if (req_mask[b]) ref_mem[req_address][b*8 +: 8] = req_data[b*8 +: 8];
            end else begin
               exp_q.push_back(ref_mem[req_address]);
            end
         end
         if (clr_start && !clr_busy) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL stray_rsp: got 0x%0h, required no response", rsp_data);
         end else if (rsp_ready) begin
            check_output("rsp_order", rsp_data, exp_q.pop_front());
            rsp_count++;
         end else begin
            check_output("rsp_hold", rsp_data, exp_q[0]);
         end
      end
   end

   // Called and returns at posedge+1; holds the request until it is accepted.
   task automatic apply_stimulus(input logic wr, input logic [7:0] addr, input logic [31:0] data, input logic [3:0] mask);
      int waited = 0;
      req_valid = 1'b1;
      req_write = wr;
      req_address = addr;
      req_data = data;
      req_mask = mask;
      @(negedge clk);
      while (!req_ready && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         check_output("req_timeout", 32'(req_ready), 32'h1);
      end else begin
         hs_cycle = cycle;
         check_output("ram_en", 32'(ram_enable), 32'h1);
         check_output("ram_we", 32'(ram_write_enable), 32'(wr));
         check_output("ram_addr", 32'(ram_address), 32'(addr));
         if (wr) begin
            check_output("ram_din", ram_data_ingress, data);
            check_output("ram_mask", 32'(ram_write_mask), 32'(mask));
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_write = 1'b0;
   endtask

   task automatic expect_read(input logic [7:0] addr, input logic [31:0] expected, input string name);
      int waited = 0;
      apply_stimulus(1'b0, addr, 32'h0, 4'h0);
      @(negedge clk);
      while (!rsp_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_output({name, "_data"}, rsp_data, expected);
      check_output({name, "_lat"}, 32'(cycle - hs_cycle), 32'd2);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      clr_start = 1'b1;
      @(posedge clk);
      #1;
      clr_start = 1'b0;
   endtask

   task automatic drain(input string name);
      int waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      check_output(name, 32'(exp_q.size()), 32'h0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acc;
      int busy;
      int base_count;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_address = 8'h0;
      req_data = 32'h0;
      req_mask = 4'h0;
      rsp_ready = 1'b1;
      clr_start = 1'b0;
      #12;
      check_output("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check_output("rst_rsp_data", rsp_data, 32'h0);
      check_output("rst_clr_busy", 32'(clr_busy), 32'h0);
      check_output("rst_ram_en", 32'(ram_enable), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_output("idle_req_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;

      $display("[TB] write then read 0x05");
      apply_stimulus(1'b1, 8'h05, 32'hA1B2C3D4, 4'hF);
      expect_read(8'h05, 32'hA1B2C3D4, "rd05");

      $display("[TB] partial mask write");
      apply_stimulus(1'b1, 8'h10, 32'hFFFFFFFF, 4'hF);
      apply_stimulus(1'b1, 8'h10, 32'h11223344, 4'h5);
      expect_read(8'h10, 32'hFF22FF44, "mask5");

      $display("[TB] write immediately followed by read");
      apply_stimulus(1'b1, 8'h02, 32'h5A5A1234, 4'hF);
      expect_read(8'h02, 32'h5A5A1234, "wr_rd");

      $display("[TB] zero-mask write leaves word intact");
      apply_stimulus(1'b1, 8'h02, 32'h00000000, 4'h0);
      expect_read(8'h02, 32'h5A5A1234, "mask0");

      $display("[TB] backpressure with eight reads");
      for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 8'(i), 32'hC0DE0000 + 32'(i), 4'hF);
      base_count = rsp_count;
      rsp_ready = 1'b0;
      acc = 0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_address = 8'h0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (req_ready) acc++;
         @(posedge clk);
         #1;
         req_address = 8'(acc);
      end
      check_output("stall_accepted", 32'(acc), 32'd2);
      @(negedge clk);
      check_output("stall_ready", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 50 && acc < 8; c++) begin
         @(negedge clk);
         if (req_ready) acc++;
         @(posedge clk);
         #1;
         req_address = 8'(acc);
      end
      req_valid = 1'b0;
      drain("stall_drain");
      check_output("stall_rsp_count", 32'(rsp_count - base_count), 32'd8);

      $display("[TB] randomized traffic");
      rand_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      rsp_ready = 1'b1;
      drain("rand_drain");

      $display("[TB] clear with colliding request");
      apply_stimulus(1'b1, 8'hFF, 32'hDEADBEEF, 4'hF);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_address = 8'h30;
      req_data = 32'h12345678;
      req_mask = 4'hF;
      clr_start = 1'b1;
      @(negedge clk);
      check_output("clr_blocks_req", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1;
      clr_start = 1'b0;
      req_valid = 1'b0;
      busy = 0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (!clr_busy) break;
         busy++;
      end
      check_output("clr_cycles", 32'(busy), 32'd256);
      @(posedge clk);
      #1;
      expect_read(8'hFF, 32'h0, "clr_ff");
      expect_read(8'h30, 32'h0, "clr_30");

      $display("[TB] reset during clear with buffered responses");
      rsp_ready = 1'b0;
      apply_stimulus(1'b1, 8'h05, 32'h0BADF00D, 4'hF);
      apply_stimulus(1'b0, 8'h05, 32'h0, 4'h0);
      apply_stimulus(1'b0, 8'h10, 32'h0, 4'h0);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_output("buffered_valid", 32'(rsp_valid), 32'h1);
      @(posedge clk);
      #1;
      pulse_clear();
      repeat (40) @(posedge clk);
      #2;
      check_output("mid_clr_busy", 32'(clr_busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check_output("async_rsp_valid", 32'(rsp_valid), 32'h0);
      check_output("async_clr_busy", 32'(clr_busy), 32'h0);
      exp_q.delete();
      rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_output("post_rst_ready", 32'(req_ready), 32'h1);
      repeat (10) @(posedge clk);
      #1;
      pulse_clear();
      busy = 0;
      while (clr_busy && busy < 1000) begin
         @(posedge clk);
         busy++;
      end
      #1;
      check_output("reclear_done", 32'(clr_busy), 32'h0);
      expect_read(8'h05, 32'h0, "reclr_05");
      expect_read(8'h10, 32'h0, "reclr_10");
      drain("final_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
